sync_fifo_param: RTL

- Parametrised synchronous FIFO, the successor to the team's fixed 8x16 shift-register FIFO.
- Circular buffer with read/write pointers; no data shifting.
- Configurable width, depth and almost-full/almost-empty thresholds; occupancy count; same-cycle read+write; synchronous flush; sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in one clock domain.

---
 rtl/sync_fifo_param_if.sv | 43 ++++
 rtl/sync_fifo_param.sv | 103 ++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// ============================================================================
// Module   : sync_fifo_param_if
// Brief    : Handshake, data and status bundle for sync_fifo_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int AW = $clog2(DEPTH);

   logic              flush;
   logic              wr_en;
   logic [DATA_W-1:0] din;
   logic              rd_en;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [AW:0]       count;
   logic              overflow;
   logic              underflow;

   // Producer/consumer side
   modport master (
      output flush, wr_en, din, rd_en,
      input  dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   // FIFO side
   modport slave (
      input  flush, wr_en, din, rd_en,
      output dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Parametrised circular-buffer synchronous FIFO with occupancy
//            count, threshold flags, flush and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_MARGIN = 2,
   parameter int AE_MARGIN = 2
) (
   input  logic              clk,
   input  logic              reset,
   sync_fifo_param_if.slave  fifo
);

   localparam int          AW          = $clog2(DEPTH);
   localparam logic [AW:0] c_depth     = DEPTH[AW:0];
   localparam logic [AW:0] c_af_level  = c_depth - AF_MARGIN[AW:0];
   localparam logic [AW:0] c_ae_level  = AE_MARGIN[AW:0];

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [DATA_W-1:0] r_dout;
   logic              r_dout_valid;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_full;
   logic              w_empty;
   logic              w_rd_accept;
   logic              w_wr_accept;

   assign w_full      = (r_count == c_depth);
   assign w_empty     = (r_count == '0);
   assign w_rd_accept = fifo.rd_en && !w_empty;
   // A full FIFO still takes a write when a read frees a slot in the same cycle
   assign w_wr_accept = fifo.wr_en && (!w_full || w_rd_accept);

   // Storage array carries no reset; stale contents are never observable
   always_ff @(posedge clk) begin
      if (w_wr_accept && !fifo.flush) begin
         r_mem[r_wr_ptr] <= fifo.din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else if (fifo.flush) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_dout_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_dout_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_dout   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (fifo.wr_en && !w_wr_accept) begin
            r_overflow <= 1'b1;
         end
         if (fifo.rd_en && !w_rd_accept) begin
            r_underflow <= 1'b1;
         end
         case ({w_wr_accept, w_rd_accept})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign fifo.dout         = r_dout;
   assign fifo.dout_valid   = r_dout_valid;
   assign fifo.full         = w_full;
   assign fifo.empty        = w_empty;
   assign fifo.almost_full  = (r_count >= c_af_level);
   assign fifo.almost_empty = (r_count <= c_ae_level);
   assign fifo.count        = r_count;
   assign fifo.overflow     = r_overflow;
   assign fifo.underflow    = r_underflow;

endmodule

`default_nettype wire
